regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Sequential reader for the register file: on a start pulse, walks a contiguous range of register addresses through one spare read port.
- Streams each register value out over a valid/ready interface, for debug readout and end-of-test state checks.
- Sits beside Register_File. It drives one read-address port and consumes the matching combinational read-data output.
- Performs no writes. It is the read-side counterpart to the write port.

Parameters:
- FIRST_REG, 0, first register address dumped (0..31).
- LAST_REG, 31, last register address dumped (FIRST_REG..31). FIRST_REG > LAST_REG is illegal; the implementation flags it with a simulation $error at elaboration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE, no done pulse.
- rf_addr  output  5  read address driven to the register-file read port.
- rf_rd  input  32  combinational read data for rf_addr.
- dump_valid  output  1  dump_data, dump_index and dump_last are valid.
- dump_ready  input  1  consumer accepts the current word.
- dump_data  output  32  captured register value.
- dump_index  output  5  register address of dump_data.
- dump_last  output  1  current word is LAST_REG.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0), immediate and asynchronous:
  - state=IDLE.
  - rf_addr=0, dump_valid=0, dump_data=0, dump_index=0, dump_last=0, busy=0, done=0.
  - Internal address counter=FIRST_REG.
  - Reset mid-dump discards the dump entirely; no done pulse.
- FSM states: IDLE, READ, HOLD, DONE. All outputs are registered.
- IDLE:
  - start=1 → counter<=FIRST_REG, go to READ.
  - start in any other state is ignored (no queuing).
- READ (one cycle):
  - rf_addr=counter.
  - At the clock edge: dump_data<=rf_rd, dump_index<=counter, dump_last<=(counter==LAST_REG), dump_valid<=1, go to HOLD.
- HOLD:
  - dump_valid=1.
  - dump_data, dump_index and dump_last stay stable while dump_ready=0, for any number of cycles.
  - On dump_valid&dump_ready:
    - dump_last=1 → dump_valid<=0, go to DONE.
    - otherwise → counter<=counter+1, dump_valid<=0, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Throughput and latency:
  - One word per 2 cycles with dump_ready held high.
  - First dump_valid appears 2 cycles after the start edge.
  - A full 0..31 dump with ready held high lasts 64 cycles plus the DONE cycle.
- Counter: 5 bits, never increments past LAST_REG, so no wrap-around. FIRST_REG==LAST_REG gives a single word with dump_last=1.
- rf_addr holds the counter value in HOLD and DONE. It returns to 0 in IDLE.
- abort:
  - abort=1 in any non-IDLE state → next edge: IDLE, dump_valid=0, done=0.
  - abort has priority over dump_ready in the same cycle; the word counts as not accepted.
  - abort and start together in IDLE → start is ignored.
- Register x0: the value is passed through as read. Register_File returns 0 there; the block does not special-case it.
- Data is sampled during READ. A write to the same register in that cycle follows the register file's write-then-read semantics; the block adds no forwarding.

Test Plan:
- Full dump: preload x5=0x12345678 and x10=0xDEADBEEF, keep rst=1, pulse start, hold dump_ready=1 → 32 words, index 0..31. Word 5 = 0x12345678, word 10 = 0xDEADBEEF, word 0 = 0. dump_last only on index 31. done pulse at cycle 65 after start.
- Backpressure: dump_ready=0 for 7 cycles while on index 3 → dump_valid, dump_data and dump_index=3 held stable for all 7 cycles. Index 4 appears 2 cycles after ready rises.
- Abort: abort while on index 12 (valid=1, ready=1 in the same cycle) → next cycle IDLE, busy=0, dump_valid=0, no done. A new start then dumps from index 0.
- Reset mid-operation: drive rst=0 during HOLD at index 20 → within 1 ns all outputs are 0 and busy=0. After rst=1, a start dumps correctly from index 0.
- Single register (FIRST_REG=LAST_REG=7, x7=0xA5A5A5A5): start → one word, dump_index=7, dump_data=0xA5A5A5A5, dump_last=1, then done.
- Ignored start: pulse start at index 2 mid-dump → the dump continues unaffected and exactly one done pulse occurs.

Source files
------------

// File: rtl/regfile_dump.sv
// Sequential register-file reader: on start, walks FIRST_REG..LAST_REG through one
// read port and streams each value out over a valid/ready handshake.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rd,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_index,
    output logic        dump_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_REG);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST_REG);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dump: illegal register range FIRST_REG=%0d LAST_REG=%0d", FIRST_REG, LAST_REG);
    end

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_d;
    logic [AW-1:0]   index_d;
    logic [DW-1:0]   data_d;
    logic            valid_d, last_d, busy_d, done_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= FIRST_A;
            rf_addr    <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_index <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_addr    <= addr_d;
            dump_valid <= valid_d;
            dump_data  <= data_d;
            dump_index <= index_d;
            dump_last  <= last_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = rf_addr;
        valid_d = dump_valid;
        data_d  = dump_data;
        index_d = dump_index;
        last_d  = dump_last;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = READ;
                    cnt_d   = FIRST_A;
                    addr_d  = FIRST_A;
                end
            end
            READ: begin
                data_d  = rf_rd;
                index_d = cnt_q;
                last_d  = (cnt_q == LAST_A);
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (dump_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        addr_d  = cnt_q + AW'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        // Abort wins over a same-cycle handshake; the word is not accepted.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule
